param_seq_detector: RTL
=======================

// Module: param_seq_detector
// PURPOSE
//  Runtime-programmable serial bit-pattern detector: successor to the fixed 101010 FSM detector.
//  Pattern, length (1..MAX_LEN) and overlap mode are loaded at runtime; defaults reproduce 101010, non-overlap.
//  Adds input qualification, a registered match pulse and a saturating match counter.
//  Sits on a serial bit stream and flags pattern hits to downstream control/status logic.
// PARAMETERS
//  MAX_LEN      8          longest supported pattern, >=2
//  CNT_W        8          match counter width
//  DEF_PATTERN  8'b101010  pattern after reset (low DEF_LEN bits used)
//  DEF_LEN      6          pattern length after reset, 1..MAX_LEN
//  DEF_OVERLAP  0          overlap mode after reset
// PORTS
//  clk          in   1              rising-edge clock
//  reset_n      in   1              asynchronous, active-low reset
//  in_valid     in   1              x is sampled only when high
//  x            in   1              serial data bit
//  cfg_load     in   1              load cfg_* this cycle
//  cfg_pattern  in   MAX_LEN        pattern; bit[len-1] = first bit received, bit[0] = last bit
//  cfg_len      in   LW             pattern length; LW = $clog2(MAX_LEN+1)
//  cfg_overlap  in   1              1 = overlapping matches allowed
//  cnt_clr      in   1              synchronous clear of match_count
//  y            out  1              one-cycle match pulse, registered
//  match_count  out  CNT_W          saturating count of matches
//  cfg_err      out  1              one-cycle pulse: cfg_load rejected
// BEHAVIOUR
//  Reset (reset_n low, async): pattern/len/overlap <= DEF_*; hist <= 0; fill <= 0; y, cfg_err, match_count <= 0.
//  State: hist[MAX_LEN-1:0] shift register and fill counter (0..len). fill = number of valid history bits.
//    On an accepted bit: hist <= {hist[MAX_LEN-2:0], x}; fill <= min(fill+1, len).
//  Accepted bit: in_valid=1 and cfg_load=0.
//  Match condition (combinational, same cycle as the accepted bit):
//    fill >= len-1 and the low len bits of {hist, x} equal the low len bits of pattern.
//  y: registered. High exactly in the cycle after a matching accepted bit; otherwise 0. Latency 1 cycle.
//  After a match:
//    overlap=0 -> fill <= 0; the next match needs len fresh bits.
//    overlap=1 -> fill saturates at len; matches can occur on consecutive bits.
//  in_valid=0: hist, fill and y-generation are held; y=0 the following cycle.
//  match_count: +1 per match, saturates at 2^CNT_W-1 (no wrap).
//    cnt_clr has priority: cnt_clr together with a match gives 0.
//  cfg_load with 1 <= cfg_len <= MAX_LEN: latch pattern/len/overlap, fill <= 0, y <= 0.
//    Any bit presented that cycle is discarded; match_count is unaffected.
//  cfg_load with cfg_len == 0 or cfg_len > MAX_LEN: config unchanged, fill unchanged, the bit is still discarded.
//    cfg_err = 1 for one cycle.
//  len=1: every accepted bit equal to pattern[0] matches; in non-overlap mode fill returns to 0 each time.
//  Bits of pattern above len-1 are ignored.
//  Reset mid-stream: partial history is lost; y drops immediately (async).
// TESTING
//  1 Defaults, overlap=0, bits 101010101010 (in_valid=1) -> y after bits 6 and 12 only; match_count=2.
//  2 Load 6'b101010, len 6, overlap=1, same 12 bits -> y after bits 6, 8, 10, 12; match_count=4.
//  3 Default config, 101010 with in_valid low for 3 cycles between bits -> single y pulse, 1 cycle after the 6th valid bit.
//  4 Load 3'b111, len 3, overlap=1, bits 11111 -> y after bits 3, 4, 5.
//    Repeat with overlap=0 -> y after bit 3 only.
//  5 cfg_load with cfg_len=0, then 101010 -> cfg_err pulses once; default pattern still matches; y after bit 6.
//  6 CNT_W=2, 5 matches -> match_count holds 3.
//    cnt_clr asserted on a match cycle -> match_count=0.
//    reset_n low after 4 bits of 101010, released, then "10" -> no y, all outputs 0.

Source files
------------

// File: rtl/param_seq_detector.sv
// param_seq_detector
//   Runtime-programmable serial bit-pattern detector. A history shift register
//   plus a fill counter track how many valid bits are available. A window is
//   compared against the low 'len' bits of the programmed pattern. Reset
//   defaults give a 101010 non-overlapping detector.
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     qualifies x
//   x            serial data bit
//   cfg_load     load cfg_pattern/cfg_len/cfg_overlap this cycle (bit discarded)
//   cfg_pattern  pattern, bit[len-1] is the first bit received
//   cfg_len      pattern length, legal range 1..MAX_LEN
//   cfg_overlap  1 = overlapping matches allowed
//   cnt_clr      synchronous clear of match_count (wins over a match)
//   y            registered one-cycle match pulse
//   match_count  saturating match counter
//   cfg_err      one-cycle pulse when a cfg_load is rejected
module param_seq_detector #(
  parameter int unsigned           MAX_LEN     = 8,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]    DEF_PATTERN = 8'b101010,
  parameter int unsigned           DEF_LEN     = 6,
  parameter logic                  DEF_OVERLAP = 1'b0,
  localparam int unsigned          LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LW-1:0]      r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;

  logic               w_accept;
  logic               w_cfg_ok;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic [LW:0]        w_fill_p1;
  logic               w_fill_ok;
  logic               w_hit;
  logic [LW-1:0]      w_fill_next;

  assign w_accept = in_valid & ~cfg_load;
  assign w_cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

  // Window is {hist, x} truncated to MAX_LEN; only the low len bits matter.
  assign w_window = {r_hist[MAX_LEN-2:0], x};

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
  end

  // fill >= len-1 rewritten as fill+1 >= len to avoid underflow.
  assign w_fill_p1 = {1'b0, r_fill} + (LW+1)'(1);
  assign w_fill_ok = (w_fill_p1 >= {1'b0, r_len});
  assign w_hit     = w_accept && w_fill_ok && (((w_window ^ r_pattern) & w_mask) == '0);

  always_comb begin
    w_fill_next = r_fill;
    if (w_hit && !r_overlap) begin
      w_fill_next = '0;
    end else if (w_fill_p1 > {1'b0, r_len}) begin
      w_fill_next = r_len;
    end else begin
      w_fill_next = w_fill_p1[LW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= LW'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      y         <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      y       <= w_hit;
      cfg_err <= cfg_load & ~w_cfg_ok;
      if (cfg_load) begin
        if (w_cfg_ok) begin
          r_pattern <= cfg_pattern;
          r_len     <= cfg_len;
          r_overlap <= cfg_overlap;
          r_fill    <= '0;
        end
      end else if (in_valid) begin
        r_hist <= w_window;
        r_fill <= w_fill_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= '0;
    end else if (w_hit && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule
